// File: rtl/rmii_rx.sv
// RMII 100 Mb/s receiver: preamble/SFD detection, dibit-to-byte assembly, CRC-32 check,
// and a 5-byte delay line so the FCS is removed before bytes reach the AXI-Stream output.
module rmii_rx #(
    parameter int MAX_BYTES = 1522
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crs_dv,
    input  logic [1:0]  rxd,
    input  logic        rx_er,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);
    localparam int CW = $clog2(MAX_BYTES + 2);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_BYTES);
    localparam logic [CW-1:0] HOLD_C = CW'(5);
    localparam logic [CW-1:0] RUNT_C = CW'(6);
    // Good-frame residue, written MSB-first; the register below holds it bit-reflected.
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [5:0]    shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   crc_q, crc_d;
    logic          err_q, err_d;
    logic          low_q, low_d;
    logic [7:0]    dl_q [5];
    logic [7:0]    tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic [15:0]   ok_q, ok_d, bad_q, bad_d;
    logic          push, ok_inc, bad_inc;
    logic          frame_end, byte_done;
    logic [7:0]    new_byte;
    logic [31:0]   crc_rev;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            r = (r >> 1) ^ ((r[0] ^ b[k]) ? 32'hEDB88320 : 32'h0);
        end
        return r;
    endfunction

    assign frame_end = (state_q == DATA) && !crs_dv && (idx_q == 2'd0);
    assign byte_done = (state_q == DATA) && !frame_end && (idx_q == 2'd3);
    assign new_byte  = {rxd, shift_q};
    assign crc_rev   = {<<{crc_q}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (crs_dv && rxd == 2'b01) state_d = PREAMBLE;
            PREAMBLE: begin
                if (!crs_dv)             state_d = IDLE;
                else if (rxd == 2'b11)   state_d = DATA;
                else if (rxd == 2'b10)   state_d = DROP;
            end
            DATA: begin
                if (frame_end)                       state_d = IDLE;
                else if (byte_done && cnt_q == MAX_C) state_d = DROP;
            end
            DROP:     if (!crs_dv && low_q) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d    = idx_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        err_d    = err_q;
        low_d    = 1'b0;
        push     = 1'b0;
        tdata_d  = tdata_q;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tuser_d  = 1'b0;
        ok_inc   = 1'b0;
        bad_inc  = 1'b0;
        case (state_q)
            PREAMBLE: if (crs_dv) begin
                if (rxd == 2'b11) begin
                    idx_d = 2'd0;
                    cnt_d = '0;
                    crc_d = 32'hFFFFFFFF;
                    err_d = 1'b0;
                end else if (rxd == 2'b10) begin
                    bad_inc = 1'b1;
                end
            end
            DATA: begin
                if (rx_er) err_d = 1'b1;
                if (frame_end) begin
                    if (cnt_q < RUNT_C) begin
                        bad_inc = 1'b1;
                    end else begin
                        // The four bytes still held are the FCS and are dropped here.
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        tdata_d  = dl_q[4];
                        tuser_d  = (crc_rev != RESIDUE) || err_q || rx_er;
                        ok_inc   = !tuser_d;
                        bad_inc  = tuser_d;
                    end
                end else begin
                    idx_d   = idx_q + 2'd1;
                    shift_d = {rxd, shift_q[5:2]};
                    if (idx_q == 2'd3) begin
                        push  = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                        crc_d = crc_byte(crc_q, new_byte);
                        if (cnt_q >= HOLD_C) begin
                            tvalid_d = 1'b1;
                            tdata_d  = dl_q[4];
                            if (cnt_q == MAX_C) begin
                                tlast_d = 1'b1;
                                tuser_d = 1'b1;
                            end
                        end
                        if (cnt_q == MAX_C) bad_inc = 1'b1;
                    end
                end
            end
            DROP:    low_d = !crs_dv;
            default: ;
        endcase
        ok_d  = (ok_inc  && ok_q  != 16'hFFFF) ? ok_q  + 16'd1 : ok_q;
        bad_d = (bad_inc && bad_q != 16'hFFFF) ? bad_q + 16'd1 : bad_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            crc_q    <= 32'hFFFFFFFF;
            err_q    <= 1'b0;
            low_q    <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            ok_q     <= '0;
            bad_q    <= '0;
            for (int k = 0; k < 5; k++) dl_q[k] <= '0;
        end else begin
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            err_q    <= err_d;
            low_q    <= low_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            ok_q     <= ok_d;
            bad_q    <= bad_d;
            if (push) begin
                dl_q[0] <= new_byte;
                for (int k = 1; k < 5; k++) dl_q[k] <= dl_q[k-1];
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign frames_ok     = ok_q;
    assign frames_bad    = bad_q;
endmodule

// File: tb/tb_rmii_rx.sv
// Scoreboard bench for rmii_rx: two instances (default and MAX_BYTES=64) share one RMII stimulus.
module tb_rmii_rx;
    logic        clk = 1'b0;
    logic        rst_n, crs_dv, rx_er;
    logic [1:0]  rxd;
    logic [7:0]  td0, td1;
    logic        tv0, tv1, tl0, tl1, tu0, tu1;
    logic [15:0] ok0, ok1, bad0, bad1;

    typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
    beat_t      q0[$], q1[$];
    logic [7:0] frm[$];
    int         checks = 0, errors = 0;
    int         eok0 = 0, ebad0 = 0, eok1 = 0, ebad1 = 0;

    always #10 clk = ~clk;

    rmii_rx dut (
        .clk(clk), .rst_n(rst_n), .crs_dv(crs_dv), .rxd(rxd), .rx_er(rx_er),
        .m_axis_tdata(td0), .m_axis_tvalid(tv0), .m_axis_tlast(tl0), .m_axis_tuser(tu0),
        .frames_ok(ok0), .frames_bad(bad0)
    );
    rmii_rx #(.MAX_BYTES(64)) dut_s (
        .clk(clk), .rst_n(rst_n), .crs_dv(crs_dv), .rxd(rxd), .rx_er(rx_er),
        .m_axis_tdata(td1), .m_axis_tvalid(tv1), .m_axis_tlast(tl1), .m_axis_tuser(tu1),
        .frames_ok(ok1), .frames_bad(bad1)
    );

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) r = (r >> 1) ^ ((r[0] ^ b[k]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expected beat per tvalid pulse.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n === 1'b1 && tv0 === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL beat_main: unexpected beat d=%h l=%b u=%b", td0, tl0, tu0);
            end else begin
                e = q0.pop_front();
                if ({td0, tl0, tu0} !== e) begin
                    errors++;
                    $display("FAIL beat_main: got d=%h l=%b u=%b expected d=%h l=%b u=%b",
                             td0, tl0, tu0, e.d, e.l, e.u);
                end
            end
        end
    end
    always @(negedge clk) begin
        beat_t e;
        if (rst_n === 1'b1 && tv1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL beat_small: unexpected beat d=%h l=%b u=%b", td1, tl1, tu1);
            end else begin
                e = q1.pop_front();
                if ({td1, tl1, tu1} !== e) begin
                    errors++;
                    $display("FAIL beat_small: got d=%h l=%b u=%b expected d=%h l=%b u=%b",
                             td1, tl1, tu1, e.d, e.l, e.u);
                end
            end
        end
    end

    task automatic dibit(input logic [1:0] d, input logic dv, input logic er);
        crs_dv = dv; rxd = d; rx_er = er;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [3:0] dv, input logic er);
        for (int i = 0; i < 4; i++) dibit(b[2*i +: 2], dv[i], er && (i == 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) dibit(2'b00, 1'b0, 1'b0);
    endtask

    task automatic preamble();
        for (int i = 0; i < 7; i++) send_byte(8'h55, 4'hF, 1'b0);
        send_byte(8'hD5, 4'hF, 1'b0);
    endtask

    // n payload bytes start, start+1, ... followed by their FCS (optionally corrupted).
    task automatic build(input int n, input logic [7:0] start, input logic flip);
        logic [31:0] c;
        logic [7:0]  t;
        c = 32'hFFFFFFFF;
        frm = {};
        for (int i = 0; i < n; i++) begin
            t = start + 8'(i);
            frm.push_back(t);
            c = crc_byte(c, t);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
        if (flip) begin
            t = frm[n];
            t[0] = ~t[0];
            frm[n] = t;
        end
    endtask

    task automatic expect_beats(input bit s, input int n, input bit last, input bit user);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = frm[i];
            b.l = last && (i == n - 1);
            b.u = user && (i == n - 1);
            if (s) q1.push_back(b);
            else   q0.push_back(b);
        end
    endtask

    task automatic tx_frame(input string name, input int er_byte, input int tog_byte);
        preamble();
        for (int k = 0; k < frm.size(); k++)
            send_byte(frm[k], (k == tog_byte) ? 4'b0101 : 4'hF, k == er_byte);
        idle(12);
        $display("frame %s: %0d bytes after SFD", name, frm.size());
    endtask

    task automatic post(input string name);
        chk({name, "_pending_main"}, q0.size(), 0);
        chk({name, "_pending_small"}, q1.size(), 0);
        chk({name, "_ok_main"}, ok0, eok0);
        chk({name, "_bad_main"}, bad0, ebad0);
        chk({name, "_ok_small"}, ok1, eok1);
        chk({name, "_bad_small"}, bad1, ebad1);
    endtask

    initial begin
        rst_n = 1'b0; crs_dv = 1'b0; rxd = 2'b00; rx_er = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_main", {td0, tv0, tl0, tu0}, 0);
        chk("reset_out_small", {td1, tv1, tl1, tu1}, 0);
        chk("reset_cnt_main", {ok0, bad0}, 0);
        chk("reset_cnt_small", {ok1, bad1}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4);

        // Reset after byte 20: the 15 bytes already through the delay line appear, nothing else.
        build(60, 8'h80, 1'b0);
        expect_beats(0, 15, 0, 0);
        expect_beats(1, 15, 0, 0);
        preamble();
        for (int k = 0; k < 20; k++) send_byte(frm[k], 4'hF, 1'b0);
        dibit(2'b00, 1'b1, 1'b0);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(8);
        $display("frame reset_abort: reset after byte 20");
        post("reset_abort");

        build(60, 8'h00, 1'b0);
        expect_beats(0, 60, 1, 0); expect_beats(1, 60, 1, 0);
        eok0++; eok1++;
        tx_frame("good", -1, -1);
        post("good");

        build(60, 8'h00, 1'b1);
        expect_beats(0, 60, 1, 1); expect_beats(1, 60, 1, 1);
        ebad0++; ebad1++;
        tx_frame("bad_fcs", -1, -1);
        post("bad_fcs");

        build(60, 8'h10, 1'b0);
        expect_beats(0, 60, 1, 1); expect_beats(1, 60, 1, 1);
        ebad0++; ebad1++;
        tx_frame("rx_er", 10, -1);
        post("rx_er");

        build(0, 8'h00, 1'b0);
        ebad0++; ebad1++;
        tx_frame("runt4", -1, -1);
        post("runt4");

        build(1, 8'h33, 1'b0);
        ebad0++; ebad1++;
        tx_frame("runt5", -1, -1);
        post("runt5");

        build(2, 8'hC1, 1'b0);
        expect_beats(0, 2, 1, 0); expect_beats(1, 2, 1, 0);
        eok0++; eok1++;
        tx_frame("min6", -1, -1);
        post("min6");

        // Preamble broken by a 10 dibit: DROP until two idle clocks.
        send_byte(8'h55, 4'hF, 1'b0);
        dibit(2'b01, 1'b1, 1'b0);
        dibit(2'b10, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) send_byte(8'hD5, 4'hF, 1'b0);
        idle(12);
        ebad0++; ebad1++;
        $display("frame bad_preamble: 10 dibit inside preamble");
        post("bad_preamble");

        build(60, 8'h40, 1'b0);
        expect_beats(0, 60, 1, 0); expect_beats(1, 60, 1, 0);
        eok0++; eok1++;
        tx_frame("toggle", -1, 17);
        post("toggle");

        // Carrier with non-preamble dibits in IDLE must stay silent.
        dibit(2'b00, 1'b1, 1'b0); dibit(2'b10, 1'b1, 1'b0);
        dibit(2'b11, 1'b1, 1'b0); dibit(2'b00, 1'b1, 1'b0);
        idle(8);
        $display("frame garbage: carrier without preamble");
        post("garbage");

        build(96, 8'h05, 1'b0);
        expect_beats(0, 96, 1, 0); eok0++;
        expect_beats(1, 60, 1, 1); ebad1++;
        tx_frame("overlength", -1, -1);
        post("overlength");

        build(60, 8'hA0, 1'b0);
        expect_beats(0, 60, 1, 0); expect_beats(1, 60, 1, 0);
        eok0++; eok1++;
        tx_frame("recover", -1, -1);
        post("recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
